axi_pack_arbiter: RTL and testbench
===================================

# axi_pack_arbiter

Round-robin controller that shares one AXI4-style packet `master` between N_REQ requesters. It grants the master to one requester for a whole packet and streams that requester's words into the master's load port (`write`/`buffer_in`) with the requester's `marker_pos`. It then holds the grant until the master has finished transmitting. It sits directly in front of `master`, replacing the single-source testbench drive of `write`, `buffer_in` and `marker_pos`.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- PACK_SIZE, 8, word width in bits (matches master PACK_SIZE)
- MARK_SIZE, 8, maximum words per packet
- TIMEOUT, 16, cycles to wait for `m_busy` to rise after load

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  requester i wants the master
- req_valid  in  N_REQ  requester i presents a word
- req_last  in  N_REQ  word presented by requester i is the final word of its packet
- req_data  in  N_REQ*PACK_SIZE  requester i word at bits [i*PACK_SIZE +: PACK_SIZE]
- req_marker  in  N_REQ*2  requester i marker_pos at bits [2i +: 2]
- req_ack  out  N_REQ  word from requester i accepted this cycle (combinational)
- grant  out  N_REQ  one-hot, registered owner of the master
- m_write  out  1  to master `write`
- m_buffer_in  out  PACK_SIZE  to master `buffer_in`
- m_marker_pos  out  2  to master `marker_pos`
- m_busy  in  1  master is transmitting its buffer
- err_overflow  out  1  one-cycle pulse: packet truncated at MARK_SIZE words
- err_timeout  out  1  one-cycle pulse: `m_busy` never rose

## Operation
- FSM states: IDLE, LOAD, WAIT_START, WAIT_DONE.
- IDLE: `grant` is 0. If `req` is nonzero, select the winner by round robin, searching from ptr+1 upward with wrap. Register the one-hot `grant`, latch `req_marker[winner]` into `m_marker_pos`, set ptr = winner, clear `beat_cnt`, and go to LOAD.
- `req` is sampled only in IDLE. Deasserting `req` after the grant has no effect; the packet runs to completion.
- LOAD:
  - `req_ack[i] = grant[i] & req_valid[i]`. All other `req_ack` bits are 0.
  - On each ack: next cycle `m_write` = 1, `m_buffer_in` = the accepted word, and `beat_cnt` increments.
  - With no ack: next cycle `m_write` = 0, and `m_buffer_in` holds its last value.
  - An ack with `req_last` goes to WAIT_START.
  - An ack with `beat_cnt` == MARK_SIZE-1 and no `req_last` also goes to WAIT_START and pulses `err_overflow`. The requester's remaining words are not acked in this packet.
- WAIT_START: `m_write` = 0. Clear the timer and count cycles. If `m_busy` = 1, go to WAIT_DONE. If the timer reaches TIMEOUT-1 with `m_busy` still 0, pulse `err_timeout` and go to IDLE.
- WAIT_DONE: stay while `m_busy` = 1. When `m_busy` = 0, clear `grant` and go to IDLE.
- `beat_cnt` is $clog2(MARK_SIZE+1) bits wide. The timer is $clog2(TIMEOUT) bits wide and saturates at its terminal value.
- Reset (asserted low, any state): FSM to IDLE; `grant`, `req_ack`, `m_write`, `m_buffer_in`, `m_marker_pos`, `err_*`, `beat_cnt` and timer all 0; ptr = N_REQ-1, so requester 0 has first priority.

## Timing
- `req` seen at edge t in IDLE: `grant` valid after t. First ack is possible in cycle t+1.
- Word acked at edge k: `m_write` and `m_buffer_in` show it after edge k. Latency is 1 cycle, with no bubbles for back-to-back valid words.
- `m_marker_pos` is stable from the grant until the return to IDLE.
- Minimum packet occupancy is 1 grant cycle, plus W load cycles, plus at least 1 WAIT_START cycle, plus the busy time.
- `req` and `req_valid` arriving on the same cycle in IDLE: no ack in that cycle, because `grant` is not yet set.
- If `m_busy` is already high on entry to WAIT_START, go to WAIT_DONE on the next edge.
- A return to IDLE and a new request on the same edge: IDLE arbitrates on the following edge. There is one dead IDLE cycle between packets.
- `err_*` pulses last exactly 1 cycle.

## Test plan
- Reset released while `req` = 4'b0001 and requester 0 sends 4 words (8'hDF, 8'h00, 8'hF0, 8'h0F, last on 8'h0F), then `m_busy` is high for 3 cycles: `grant` = 0001, `m_write` is high for exactly 4 cycles with those words in order, and the FSM returns to IDLE after `m_busy` falls.
- `req` = 4'b1111 held for four packets of 1 word each: grant order 0, 1, 2, 3, then 0 again.
- Requester 2 streams 10 words with no `req_last`: 8 words are written, `err_overflow` pulses on the ack of the 8th word, and `req_ack[2]` is 0 afterwards.
- `m_busy` is held 0 after load: `err_timeout` pulses 16 cycles into WAIT_START, `grant` clears, and the next requester is served.
- `req_valid` toggles 1, 0, 1 during LOAD: `m_write` shows the gap 1 cycle later and `beat_cnt` ends at 2.
- Reset asserted mid-LOAD after 2 words: all outputs are 0 immediately (asynchronous). After release, requester 0 wins even though another requester was being served.

Source files
------------

// File: rtl/axi_pack_arbiter.sv
// Round-robin packet arbiter in front of a single AXI4-style packet master:
// grants one requester per packet, streams its words into the master, then waits out transmission.
module axi_pack_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned PACK_SIZE = 8,
    parameter int unsigned MARK_SIZE = 8,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ-1:0]           i_req_last,
    input  logic [N_REQ*PACK_SIZE-1:0] i_req_data,
    input  logic [2*N_REQ-1:0]         i_req_marker,
    output logic [N_REQ-1:0]           o_req_ack_c,
    output logic [N_REQ-1:0]           o_grant,
    output logic                       o_m_write,
    output logic [PACK_SIZE-1:0]       o_m_buffer_in,
    output logic [1:0]                 o_m_marker_pos,
    input  logic                       i_m_busy,
    output logic                       o_err_overflow,
    output logic                       o_err_timeout
);

    localparam int unsigned PTR_W  = $clog2(N_REQ);
    localparam int unsigned BEAT_W = $clog2(MARK_SIZE + 1);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_LOAD       = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_DONE  = 2'd3
    } state_t;

    state_t                r_state,          w_state_nxt;
    logic [N_REQ-1:0]      r_grant,          w_grant_nxt;
    logic [PTR_W-1:0]      r_ptr,            w_ptr_nxt;
    logic [BEAT_W-1:0]     r_beat_cnt,       w_beat_cnt_nxt;
    logic [TMR_W-1:0]      r_timer,          w_timer_nxt;
    logic                  r_m_write,        w_m_write_nxt;
    logic [PACK_SIZE-1:0]  r_m_buffer_in,    w_m_buffer_in_nxt;
    logic [1:0]            r_m_marker_pos,   w_m_marker_pos_nxt;
    logic                  r_err_overflow,   w_err_overflow_nxt;
    logic                  r_err_timeout,    w_err_timeout_nxt;

    logic [PTR_W-1:0]      w_winner;
    logic [PTR_W-1:0]      w_cand;
    logic                  w_found;
    logic [1:0]            w_sel_marker;
    logic [PACK_SIZE-1:0]  w_sel_data;
    logic                  w_sel_last;
    logic                  w_ack_any;

    // Round-robin search starting just after the last winner, wrapping around.
    always_comb begin
        w_winner = r_ptr;
        w_cand   = '0;
        w_found  = 1'b0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            w_cand = PTR_W'((int'(r_ptr) + k) % int'(N_REQ));
            if (!w_found && i_req[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_marker = '0;
        w_sel_data   = '0;
        w_sel_last   = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_winner == PTR_W'(i)) w_sel_marker = i_req_marker[2*i +: 2];
            if (r_grant[i]) begin
                w_sel_data = i_req_data[i*PACK_SIZE +: PACK_SIZE];
                w_sel_last = i_req_last[i];
            end
        end
    end

    assign o_req_ack_c = (r_state == S_LOAD) ? (r_grant & i_req_valid) : '0;
    assign w_ack_any   = |o_req_ack_c;

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt        = r_state;
        w_grant_nxt        = r_grant;
        w_ptr_nxt          = r_ptr;
        w_beat_cnt_nxt     = r_beat_cnt;
        w_timer_nxt        = r_timer;
        w_m_write_nxt      = 1'b0;
        w_m_buffer_in_nxt  = r_m_buffer_in;
        w_m_marker_pos_nxt = r_m_marker_pos;
        w_err_overflow_nxt = 1'b0;
        w_err_timeout_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_grant_nxt        = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
                    w_m_marker_pos_nxt = w_sel_marker;
                    w_ptr_nxt          = w_winner;
                    w_beat_cnt_nxt     = '0;
                    w_state_nxt        = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_ack_any) begin
                    w_m_write_nxt     = 1'b1;
                    w_m_buffer_in_nxt = w_sel_data;
                    w_beat_cnt_nxt    = r_beat_cnt + BEAT_W'(1);
                    if (w_sel_last) begin
                        w_timer_nxt = '0;
                        w_state_nxt = S_WAIT_START;
                    end else if (r_beat_cnt == BEAT_W'(MARK_SIZE - 1)) begin
                        w_err_overflow_nxt = 1'b1;
                        w_timer_nxt        = '0;
                        w_state_nxt        = S_WAIT_START;
                    end
                end
            end
            S_WAIT_START: begin
                if (i_m_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                    w_err_timeout_nxt = 1'b1;
                    w_grant_nxt       = '0;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!i_m_busy) begin
                    w_grant_nxt = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_grant        <= '0;
            r_ptr          <= PTR_W'(N_REQ - 1);
            r_beat_cnt     <= '0;
            r_timer        <= '0;
            r_m_write      <= 1'b0;
            r_m_buffer_in  <= '0;
            r_m_marker_pos <= '0;
            r_err_overflow <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_grant        <= w_grant_nxt;
            r_ptr          <= w_ptr_nxt;
            r_beat_cnt     <= w_beat_cnt_nxt;
            r_timer        <= w_timer_nxt;
            r_m_write      <= w_m_write_nxt;
            r_m_buffer_in  <= w_m_buffer_in_nxt;
            r_m_marker_pos <= w_m_marker_pos_nxt;
            r_err_overflow <= w_err_overflow_nxt;
            r_err_timeout  <= w_err_timeout_nxt;
        end
    end

    assign o_grant        = r_grant;
    assign o_m_write      = r_m_write;
    assign o_m_buffer_in  = r_m_buffer_in;
    assign o_m_marker_pos = r_m_marker_pos;
    assign o_err_overflow = r_err_overflow;
    assign o_err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_axi_pack_arbiter.sv
// Bench for axi_pack_arbiter: directed scenarios plus random packets checked against a packet-level model.
module tb_axi_pack_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MS = 8;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   i_req = '0;
    logic [N-1:0]   i_req_valid = '0;
    logic [N-1:0]   i_req_last = '0;
    logic [N*W-1:0] i_req_data = '0;
    logic [2*N-1:0] i_req_marker = '0;
    logic           i_m_busy = 1'b0;
    logic [N-1:0]   o_req_ack_c;
    logic [N-1:0]   o_grant;
    logic           o_m_write;
    logic [W-1:0]   o_m_buffer_in;
    logic [1:0]     o_m_marker_pos;
    logic           o_err_overflow;
    logic           o_err_timeout;

    axi_pack_arbiter #(.N_REQ(N), .PACK_SIZE(W), .MARK_SIZE(MS), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req(i_req), .i_req_valid(i_req_valid), .i_req_last(i_req_last),
        .i_req_data(i_req_data), .i_req_marker(i_req_marker),
        .o_req_ack_c(o_req_ack_c), .o_grant(o_grant),
        .o_m_write(o_m_write), .o_m_buffer_in(o_m_buffer_in), .o_m_marker_pos(o_m_marker_pos),
        .i_m_busy(i_m_busy),
        .o_err_overflow(o_err_overflow), .o_err_timeout(o_err_timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int mptr     = N - 1;
    logic [W-1:0] words [0:15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next owner: first requester after the previous owner, wrapping.
    function automatic int rr_model(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(o_grant), 32'd0);
        chk({tag, "_ack"}, 32'(o_req_ack_c), 32'd0);
        chk({tag, "_write"}, 32'(o_m_write), 32'd0);
        chk({tag, "_buf"}, 32'(o_m_buffer_in), 32'd0);
        chk({tag, "_marker"}, 32'(o_m_marker_pos), 32'd0);
        chk({tag, "_errs"}, 32'({o_err_overflow, o_err_timeout}), 32'd0);
    endtask

    // One packet: arbitration, load of nwords (capped at MS), then the wait for the master.
    // vmode: 0 always valid, 1 random gaps, 2 pattern 1,0,1...; blen==0 means busy never rises.
    task automatic run_packet(input logic [N-1:0] reqv, input int nwords, input bit send_last,
                              input int vmode, input int bdelay, input int blen,
                              input int abort_after);
        logic [1:0]   mk [N];
        logic [N-1:0] oh;
        int           win, beats, j, e;
        bit           v, is_last, done, tmo;
        for (int i = 0; i < N; i++) begin
            mk[i] = 2'($urandom());
            i_req_marker[2*i +: 2] = mk[i];
        end
        win = rr_model(reqv, mptr);
        oh  = N'(1) << win;
        i_req       = reqv;
        i_req_valid = '1;
        #1;
        chk("idle_ack", 32'(o_req_ack_c), 32'd0);
        step();
        chk("grant", 32'(o_grant), 32'(oh));
        chk("marker", 32'(o_m_marker_pos), 32'(mk[win]));
        chk("idle_write", 32'(o_m_write), 32'd0);
        chk("idle_errs", 32'({o_err_overflow, o_err_timeout}), 32'd0);
        mptr  = win;
        i_req = '0;
        beats = 0;
        done  = 1'b0;
        j     = 0;
        while (!done) begin
            case (vmode)
                0:       v = 1'b1;
                2:       v = (j != 1);
                default: v = (j % 4 == 3) || ($urandom_range(0, 1) == 1);
            endcase
            is_last          = send_last && (beats == nwords - 1);
            i_req_valid      = N'($urandom());
            i_req_valid[win] = v;
            i_req_last       = N'($urandom());
            i_req_last[win]  = is_last;
            i_req_data       = (N*W)'($urandom());
            i_req_data[win*W +: W] = words[beats];
            #1;
            chk("load_ack", 32'(o_req_ack_c), v ? 32'(oh) : 32'd0);
            step();
            chk("m_write", 32'(o_m_write), 32'(v));
            if (v) chk("m_buffer_in", 32'(o_m_buffer_in), 32'(words[beats]));
            chk("err_overflow", 32'(o_err_overflow), 32'(v && !is_last && beats == MS - 1));
            chk("grant_hold", 32'(o_grant), 32'(oh));
            if (v) begin
                beats++;
                if (is_last || beats == MS) done = 1'b1;
            end
            if (abort_after >= 0 && beats == abort_after) return;
            j++;
            if (j > 100) begin
                checks++;
                failures++;
                $error("FAIL load_bound observed_beats=%0d expected_beats=%0d", beats, nwords);
                return;
            end
        end
        tmo = (blen == 0) || (bdelay >= TO);
        e   = tmo ? TO - 1 : bdelay + blen;
        for (int c = 0; c <= e; c++) begin
            i_m_busy    = !tmo && (c >= bdelay) && (c < bdelay + blen);
            i_req_valid = '1;
            i_req_last  = N'($urandom());
            #1;
            chk("wait_ack", 32'(o_req_ack_c), 32'd0);
            step();
            chk("wait_write", 32'(o_m_write), 32'd0);
            chk("wait_grant", 32'(o_grant), (c < e) ? 32'(oh) : 32'd0);
            chk("err_timeout", 32'(o_err_timeout), 32'((c == e) && tmo));
            chk("wait_ovf", 32'(o_err_overflow), 32'd0);
            chk("marker_hold", 32'(o_m_marker_pos), 32'(mk[win]));
        end
        i_m_busy    = 1'b0;
        i_req_valid = '0;
        i_req_last  = '0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        mptr = N - 1;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state, then release with requester 0 already requesting.
        i_req = 4'b0001;
        #3;
        chk_all_zero("por");
        #19;
        rst_n = 1'b1;
        words[0] = 8'hDF; words[1] = 8'h00; words[2] = 8'hF0; words[3] = 8'h0F;
        run_packet(4'b0001, 4, 1'b1, 0, 0, 3, -1);

        // Fair rotation with all four requesting, one word each.
        do_reset();
        for (int p = 0; p < 5; p++) begin
            words[0] = W'($urandom());
            run_packet(4'b1111, 1, 1'b1, 0, 0, 1, -1);
        end

        // Requester 2 never marks a last word: truncation at MS words.
        for (int i = 0; i < 16; i++) words[i] = W'($urandom());
        run_packet(4'b0100, 10, 1'b0, 0, 2, 2, -1);

        // Master never becomes busy: timeout, then the next requester is served.
        run_packet(4'b0011, 3, 1'b1, 0, 99, 0, -1);
        run_packet(4'b0011, 2, 1'b1, 0, 0, 2, -1);

        // Valid pattern 1,0,1 and busy already high on entry to the wait.
        run_packet(4'b1000, 2, 1'b1, 2, 0, 4, -1);

        // Asynchronous reset in the middle of a load.
        for (int i = 0; i < 16; i++) words[i] = W'($urandom());
        run_packet(4'b0100, 5, 1'b1, 0, 0, 1, 2);
        i_req_valid = '1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midload_reset");
        mptr = N - 1;
        #2;
        rst_n = 1'b1;
        i_req_valid = '0;
        run_packet(4'b1111, 1, 1'b1, 0, 1, 1, -1);

        // Random packets.
        for (int p = 0; p < 14; p++) begin
            logic [N-1:0] r;
            r = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < 16; i++) words[i] = W'($urandom());
            run_packet(r, $urandom_range(1, 10), ($urandom_range(0, 3) != 0), 1,
                       $urandom_range(0, 20), $urandom_range(0, 4), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
